// File: rtl/rtc_bus_driver.sv
// Runs one multiplexed address/data bus cycle on the external RTC chip pins.
// Pin outputs are registered from the current phase, so the pins trail the phase sequencer by one cycle.
module rtc_bus_driver #(
   parameter int unsigned T_SET = 2,
   parameter int unsigned T_PUL = 4,
   parameter int unsigned T_HLD = 2,
   parameter int unsigned T_GAP = 2
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       escritura,
   input  logic [7:0] dir_in,
   input  logic [7:0] dato_wr,
   output logic [7:0] dato_rd,
   output logic       fin,
   output logic       ocupado,
   output logic [7:0] AD_out,
   output logic       AD_oe,
   input  logic [7:0] AD_in,
   output logic       AD_sel,
   output logic       CS_n,
   output logic       RD_n,
   output logic       WR_n
);

   localparam int unsigned CNT_W = 8;

   localparam logic [CNT_W-1:0] LD_SET = CNT_W'(T_SET - 1);
   localparam logic [CNT_W-1:0] LD_PUL = CNT_W'(T_PUL - 1);
   localparam logic [CNT_W-1:0] LD_HLD = CNT_W'(T_HLD - 1);
   localparam logic [CNT_W-1:0] LD_GAP = CNT_W'(T_GAP - 1);

   if (T_SET < 1 || T_SET > 255 || T_PUL < 1 || T_PUL > 255 ||
       T_HLD < 1 || T_HLD > 255 || T_GAP < 1 || T_GAP > 255) begin : g_bad_param
      $error("rtc_bus_driver: timing parameters must lie in 1..255");
   end

   typedef enum logic [3:0] {
      IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, GAP, DONE
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_q, wr_d;
   logic [7:0]       addr_q, addr_d;
   logic [7:0]       data_q, data_d;

   logic [7:0]       dato_rd_q, dato_rd_d;
   logic             fin_q, fin_d;
   logic             ocupado_q, ocupado_d;
   logic [7:0]       ad_out_q, ad_out_d;
   logic             ad_oe_q, ad_oe_d;
   logic             ad_sel_q, ad_sel_d;
   logic             cs_n_q, cs_n_d;
   logic             rd_n_q, rd_n_d;
   logic             wr_n_q, wr_n_d;

   logic             last;

   // Phase sequencer: each timed phase reloads the down-counter on entry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      data_d  = data_q;
      last    = (cnt_q == '0);
      unique case (state_q)
         IDLE: begin
            if (iniciar) begin
               wr_d    = escritura;
               addr_d  = dir_in;
               data_d  = dato_wr;
               state_d = A_SET;
               cnt_d   = LD_SET;
            end
         end
         A_SET: if (last) begin state_d = A_STB; cnt_d = LD_PUL; end else cnt_d = cnt_q - 8'd1;
         A_STB: if (last) begin state_d = A_HLD; cnt_d = LD_HLD; end else cnt_d = cnt_q - 8'd1;
         A_HLD: if (last) begin state_d = D_SET; cnt_d = LD_SET; end else cnt_d = cnt_q - 8'd1;
         D_SET: if (last) begin state_d = D_STB; cnt_d = LD_PUL; end else cnt_d = cnt_q - 8'd1;
         D_STB: if (last) begin state_d = D_HLD; cnt_d = LD_HLD; end else cnt_d = cnt_q - 8'd1;
         D_HLD: if (last) begin state_d = GAP;   cnt_d = LD_GAP; end else cnt_d = cnt_q - 8'd1;
         GAP:   if (last) begin state_d = DONE;  cnt_d = '0;     end else cnt_d = cnt_q - 8'd1;
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Pin decode for the phase currently held in state_q.
   always_comb begin
      ad_out_d  = ad_out_q;
      ad_oe_d   = 1'b0;
      ad_sel_d  = 1'b1;
      cs_n_d    = 1'b1;
      rd_n_d    = 1'b1;
      wr_n_d    = 1'b1;
      fin_d     = 1'b0;
      dato_rd_d = dato_rd_q;
      unique case (state_q)
         A_SET, A_HLD: begin
            ad_out_d = addr_q;
            ad_oe_d  = 1'b1;
            ad_sel_d = 1'b0;
         end
         A_STB: begin
            ad_out_d = addr_q;
            ad_oe_d  = 1'b1;
            ad_sel_d = 1'b0;
            cs_n_d   = 1'b0;
            wr_n_d   = 1'b0;
         end
         D_SET, D_HLD: begin
            if (wr_q) begin
               ad_out_d = data_q;
               ad_oe_d  = 1'b1;
            end
         end
         D_STB: begin
            cs_n_d = 1'b0;
            if (wr_q) begin
               ad_out_d = data_q;
               ad_oe_d  = 1'b1;
               wr_n_d   = 1'b0;
            end else begin
               rd_n_d   = 1'b0;
            end
         end
         DONE: fin_d = 1'b1;
         default: ;
      endcase
      // Read data is taken at the edge where RD_n rises.
      if (!rd_n_q && rd_n_d) dato_rd_d = AD_in;
      ocupado_d = (state_d != IDLE) || fin_d;
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         wr_q      <= 1'b0;
         addr_q    <= 8'h00;
         data_q    <= 8'h00;
         dato_rd_q <= 8'h00;
         fin_q     <= 1'b0;
         ocupado_q <= 1'b0;
         ad_out_q  <= 8'h00;
         ad_oe_q   <= 1'b0;
         ad_sel_q  <= 1'b1;
         cs_n_q    <= 1'b1;
         rd_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         dato_rd_q <= dato_rd_d;
         fin_q     <= fin_d;
         ocupado_q <= ocupado_d;
         ad_out_q  <= ad_out_d;
         ad_oe_q   <= ad_oe_d;
         ad_sel_q  <= ad_sel_d;
         cs_n_q    <= cs_n_d;
         rd_n_q    <= rd_n_d;
         wr_n_q    <= wr_n_d;
      end
   end

   assign dato_rd = dato_rd_q;
   assign fin     = fin_q;
   assign ocupado = ocupado_q;
   assign AD_out  = ad_out_q;
   assign AD_oe   = ad_oe_q;
   assign AD_sel  = ad_sel_q;
   assign CS_n    = cs_n_q;
   assign RD_n    = rd_n_q;
   assign WR_n    = wr_n_q;

endmodule

// File: tb/tb_rtc_bus_driver.sv
// Bench for rtc_bus_driver: default-timing and all-ones-timing instances checked cycle by cycle
// against a bus timeline computed from the phase lengths.
module tb_rtc_bus_driver;

   logic       CLK = 1'b0;
   logic       reset;
   logic       iniciar0, iniciar1, escritura;
   logic [7:0] dir_in, dato_wr, AD_in;

   logic [7:0] drd0, ad0, drd1, ad1;
   logic       fin0, ocu0, oe0, sel0, cs0, rd0, wr0;
   logic       fin1, ocu1, oe1, sel1, cs1, rd1, wr1;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_rd [2];

   typedef struct packed {
      logic [7:0] ad;
      logic oe, sel, cs, rd, wr, fin, ocu;
      logic [7:0] drd;
   } obs_t;

   always #5 CLK = ~CLK;

   rtc_bus_driver u_dut0 (
      .CLK(CLK), .reset(reset), .iniciar(iniciar0), .escritura(escritura),
      .dir_in(dir_in), .dato_wr(dato_wr), .dato_rd(drd0), .fin(fin0), .ocupado(ocu0),
      .AD_out(ad0), .AD_oe(oe0), .AD_in(AD_in), .AD_sel(sel0),
      .CS_n(cs0), .RD_n(rd0), .WR_n(wr0));

   rtc_bus_driver #(.T_SET(1), .T_PUL(1), .T_HLD(1), .T_GAP(1)) u_dut1 (
      .CLK(CLK), .reset(reset), .iniciar(iniciar1), .escritura(escritura),
      .dir_in(dir_in), .dato_wr(dato_wr), .dato_rd(drd1), .fin(fin1), .ocupado(ocu1),
      .AD_out(ad1), .AD_oe(oe1), .AD_in(AD_in), .AD_sel(sel1),
      .CS_n(cs1), .RD_n(rd1), .WR_n(wr1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, want);
      end
   endtask

   function automatic obs_t sample(input bit which);
      obs_t o;
      if (which) o = {ad1, oe1, sel1, cs1, rd1, wr1, fin1, ocu1, drd1};
      else       o = {ad0, oe0, sel0, cs0, rd0, wr0, fin0, ocu0, drd0};
      return o;
   endfunction

   // Expected pins k cycles after the latch edge, from the phase lengths alone.
   function automatic obs_t model(input int s, input int p, input int h, input int g,
                                  input bit wr, input logic [7:0] addr, input logic [7:0] data,
                                  input int k);
      obs_t e;
      int j  = k - 1;
      int a1 = s;
      int a2 = s + p;
      int a3 = s + p + h;
      int d1 = a3 + s;
      int d2 = a3 + s + p;
      int d3 = 2 * a3;
      int dn = d3 + g;
      e = '0;
      e.sel = 1'b1; e.cs = 1'b1; e.rd = 1'b1; e.wr = 1'b1;
      if (j >= 0 && j < a3) begin
         e.ad = addr; e.oe = 1'b1; e.sel = 1'b0;
         if (j >= a1 && j < a2) begin e.cs = 1'b0; e.wr = 1'b0; end
      end else if (j >= a3 && j < d3) begin
         if (wr) begin e.ad = data; e.oe = 1'b1; end
         if (j >= d1 && j < d2) begin
            e.cs = 1'b0;
            if (wr) e.wr = 1'b0; else e.rd = 1'b0;
         end
      end else if (j == dn) begin
         e.fin = 1'b1;
      end
      return e;
   endfunction

   task automatic set_ini(input bit which, input logic v);
      if (which) iniciar1 = v; else iniciar0 = v;
   endtask

   task automatic launch(input bit which, input bit wr, input logic [7:0] addr, input logic [7:0] data);
      escritura = wr;
      dir_in    = addr;
      dato_wr   = data;
      set_ini(which, 1'b1);
      @(posedge CLK); #1;
   endtask

   // Follows one transaction from the latch edge (k=0) to one cycle past fin.
   task automatic watch(input bit which, input bit wr, input logic [7:0] addr, input logic [7:0] data,
                        input logic [7:0] rd_val, input bit keep, input logic [7:0] naddr,
                        input logic [7:0] ndata, input bit pulses);
      int s   = which ? 1 : 2;
      int p   = which ? 1 : 4;
      int h   = which ? 1 : 2;
      int g   = which ? 1 : 2;
      int lat = 2 * (s + p + h) + g + 1;
      int cap = 2 * s + 2 * p + h + 1;
      obs_t o, e;
      logic [7:0] erd;
      for (int k = 0; k <= lat + 1; k++) begin
         if (k > 0) begin @(posedge CLK); #1; end
         o = sample(which);
         e = model(s, p, h, g, wr, addr, data, k);
         chk($sformatf("pins k=%0d", k), 32'({o.oe, o.sel, o.cs, o.rd, o.wr, o.fin}),
             32'({e.oe, e.sel, e.cs, e.rd, e.wr, e.fin}));
         if (e.oe) chk($sformatf("ad_out k=%0d", k), 32'(o.ad), 32'(e.ad));
         chk($sformatf("ocupado k=%0d", k), 32'(o.ocu), 32'((k <= lat) || keep));
         erd = (!wr && k >= cap) ? rd_val : exp_rd[which];
         chk($sformatf("dato_rd k=%0d", k), 32'(o.drd), 32'(erd));
         AD_in = (o.rd == 1'b0) ? rd_val : 8'(rd_val ^ 8'hA5);
         if (keep) begin
            escritura = 1'b1; dir_in = naddr; dato_wr = ndata;
            set_ini(which, 1'b1);
         end else begin
            escritura = 1'($urandom);
            dir_in    = 8'($urandom);
            dato_wr   = 8'($urandom);
            set_ini(which, pulses && (k == 4 || k == 11));
         end
      end
      if (!wr) exp_rd[which] = rd_val;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      obs_t o;
      int   n;
      bit   fin_seen;
      bit   w;
      logic [7:0] a, d, r;

      reset = 1'b0; iniciar0 = 1'b0; iniciar1 = 1'b0; escritura = 1'b0;
      dir_in = 8'h00; dato_wr = 8'h00; AD_in = 8'h00;
      exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset dut0", 32'(sample(1'b0)), 32'({8'h00, 7'b0111100, 8'h00}));
      chk("reset dut1", 32'(sample(1'b1)), 32'({8'h00, 7'b0111100, 8'h00}));
      reset = 1'b1;
      @(posedge CLK); #1;

      // Default-timing write and read.
      launch(1'b0, 1'b1, 8'h21, 8'h45);
      watch(1'b0, 1'b1, 8'h21, 8'h45, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      launch(1'b0, 1'b0, 8'h22, 8'h00);
      watch(1'b0, 1'b0, 8'h22, 8'h00, 8'h37, 1'b0, 8'h00, 8'h00, 1'b0);

      // Extra iniciar pulses mid-transaction are ignored.
      launch(1'b0, 1'b1, 8'h5A, 8'h96);
      watch(1'b0, 1'b1, 8'h5A, 8'h96, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
      repeat (3) @(posedge CLK);
      #1;
      chk("no extra fin", 32'({fin0, ocu0}), 32'(2'b00));

      // Back-to-back writes with iniciar held high.
      launch(1'b0, 1'b1, 8'h23, 8'h11);
      watch(1'b0, 1'b1, 8'h23, 8'h11, 8'h00, 1'b1, 8'h24, 8'h22, 1'b0);
      watch(1'b0, 1'b1, 8'h24, 8'h22, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

      // Reset during the read data strobe.
      launch(1'b0, 1'b0, 8'h22, 8'h00);
      set_ini(1'b0, 1'b0);
      n = 0;
      o = sample(1'b0);
      while (o.rd !== 1'b0 && n < 40) begin
         @(posedge CLK); #1;
         n++;
         o = sample(1'b0);
      end
      chk("reach read strobe", 32'(n < 40), 32'(1));
      AD_in = 8'h37;
      @(posedge CLK); #1;
      reset = 1'b0;
      #1;
      o = sample(1'b0);
      chk("async release", 32'({o.cs, o.rd, o.wr, o.oe, o.fin, o.ocu}), 32'(6'b111000));
      chk("reset dato_rd", 32'(o.drd), 32'(8'h00));
      exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
      #2 reset = 1'b1;
      fin_seen = 1'b0;
      repeat (25) begin
         @(posedge CLK); #1;
         if (fin0 === 1'b1) fin_seen = 1'b1;
      end
      chk("no fin after reset", 32'({fin_seen, ocu0}), 32'(2'b00));
      launch(1'b0, 1'b0, 8'h22, 8'h00);
      watch(1'b0, 1'b0, 8'h22, 8'h00, 8'h5C, 1'b0, 8'h00, 8'h00, 1'b0);

      // All-ones timing instance.
      launch(1'b1, 1'b1, 8'h3C, 8'hC3);
      watch(1'b1, 1'b1, 8'h3C, 8'hC3, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      launch(1'b1, 1'b0, 8'h7E, 8'h00);
      watch(1'b1, 1'b0, 8'h7E, 8'h00, 8'hE1, 1'b0, 8'h00, 8'h00, 1'b0);

      // Randomized transactions on both instances.
      for (int i = 0; i < 10; i++) begin
         w = 1'($urandom);
         a = 8'($urandom);
         d = 8'($urandom);
         r = 8'($urandom);
         launch(1'(i % 2), w, a, d);
         watch(1'(i % 2), w, a, d, r, 1'b0, 8'h00, 8'h00, 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rtc_bus_driver.md
Name: rtc_bus_driver

Overview:
- Downstream stage of the RTC user-control block: takes its 8-bit register address (ADD2), write data (Dato_out) and write/read request (escritura), and executes one multiplexed address/data bus cycle on the external RTC chip pins (AD[7:0], A/D select, CS_n, RD_n, WR_n).
- Returns read data (feeds the control block's Dato_in) and a one-cycle `fin` completion pulse (feeds the control block's fin input).

Parameters:
- T_SET, 2, setup cycles before each strobe (1..255)
- T_PUL, 4, strobe low width in cycles (1..255)
- T_HLD, 2, hold cycles after each strobe (1..255)
- T_GAP, 2, bus-idle cycles after the data phase, before `fin` (1..255)

Ports:
- CLK  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- iniciar  in  1  start request, sampled only in IDLE
- escritura  in  1  1 = write cycle, 0 = read cycle; latched with iniciar
- dir_in  in  8  RTC register address; latched with iniciar
- dato_wr  in  8  write data; latched with iniciar
- dato_rd  out  8  last read data
- fin  out  1  one-cycle completion pulse
- ocupado  out  1  high from the latch edge until the `fin` cycle, inclusive
- AD_out  out  8  bus drive value
- AD_oe  out  1  tristate enable for AD_out
- AD_in  in  8  bus sampled value
- AD_sel  out  1  0 = address phase, 1 = data phase
- CS_n  out  1  chip select, active low
- RD_n  out  1  read strobe, active low
- WR_n  out  1  write strobe, active low

Behaviour:
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values (reset=0): state IDLE, CS_n=1, RD_n=1, WR_n=1, AD_oe=0, AD_sel=1, AD_out=0x00, dato_rd=0x00, fin=0, ocupado=0, cycle counter=0.
- State machine states: IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, GAP, DONE.
- Each timed state lasts exactly its parameter count, using an 8-bit down-counter loaded on state entry.
- IDLE:
  - On iniciar=1 at a rising edge, latch escritura/dir_in/dato_wr, set ocupado=1, go to A_SET.
  - iniciar is ignored in every other state; there is no queueing.
- A_SET (T_SET): AD_out=address, AD_oe=1, AD_sel=0, strobes high.
- A_STB (T_PUL): CS_n=0, WR_n=0. The address is always latched with WR_n, for both reads and writes.
- A_HLD (T_HLD): CS_n=1, WR_n=1; address still driven.
- D_SET (T_SET): AD_sel=1.
  - Write: AD_out=data, AD_oe=1.
  - Read: AD_oe=0.
- D_STB (T_PUL): CS_n=0.
  - Write: WR_n=0.
  - Read: RD_n=0; AD_in is captured into dato_rd on the last cycle of D_STB, at the edge where RD_n returns high.
- D_HLD (T_HLD): strobes high. A write keeps AD_oe=1 and the data; a read keeps AD_oe=0.
- GAP (T_GAP): AD_oe=0, AD_sel=1, CS_n=1.
- DONE (1 cycle): fin=1, then IDLE with ocupado=0.
- Latency: fin is high in the cycle starting 2*(T_SET+T_PUL+T_HLD)+T_GAP+1 rising edges after the edge that sampled iniciar. Defaults give 19.
- Back-to-back operation: iniciar held high through DONE starts the next transaction at the first IDLE edge. Minimum period is therefore latency+1 cycles.
- dato_rd changes only on read-capture; writes leave it unchanged.
- Strobe rules:
  - CS_n/RD_n/WR_n never go low in IDLE, GAP or DONE.
  - RD_n and WR_n are never low simultaneously.
- Reset asserted mid-transaction releases all strobes and AD_oe immediately (asynchronously) and returns to IDLE. No fin is issued and dato_rd clears to 0x00.
- Parameter value 0 is illegal; it is flagged by a synthesis-time check.

Test Plan:
- Write, default params, dir_in=0x21, dato_wr=0x45, escritura=1, one-cycle iniciar -> AD_out=0x21 with AD_sel=0 through WR_n low for 4 cycles; then AD_out=0x45 with AD_sel=1 through a second 4-cycle WR_n low; RD_n stays 1; fin pulses exactly 19 edges later; dato_rd unchanged.
- Read, dir_in=0x22, escritura=0, AD_in=0x37 during D_STB -> AD_oe=0 during the data phase; RD_n low for 4 cycles; dato_rd=0x37 at fin; WR_n low only during the address strobe.
- iniciar pulsed again at cycles 5 and 12 of a transaction -> ignored; exactly one fin; latched address and data unaltered even though dir_in/dato_wr change mid-cycle.
- iniciar held high continuously for two writes (0x23/0x11, then 0x24/0x22) -> fin at edges 19 and 39; the second A_SET starts one cycle after the first fin.
- reset pulsed low during a read D_STB -> CS_n/RD_n go high and AD_oe goes 0 without waiting for a clock; dato_rd=0x00; no fin; a new read after reset completes normally.
- Parameters all set to 1 -> write latency = 2*3+1+1 = 8 edges; each strobe is exactly one cycle wide.
